// File: rtl/seed_sequencer.sv
// Seed selection and generation pacing for the cellular-automaton playfield.
// Define SEED_LOAD_EN to enable capturing an external seed through load/inputSeed.
module seed_sequencer #(
  parameter int          WIDTH        = 64,
  parameter logic [63:0] DEFAULT_SEED = 64'h0412_6424_0034_3CA8,
  parameter logic [63:0] TAPS         = 64'hD800_0000_0000_0000,
  parameter int          TICK_PERIOD  = 4,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             randomize,
  input  logic             load,
  input  logic [WIDTH-1:0] inputSeed,
  output logic [WIDTH-1:0] outputSeed,
  output logic             seed_valid,
  output logic             playing,
  output logic             tick,
  output logic [CNT_W-1:0] gen_count,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] DEF_SEED = WIDTH'(DEFAULT_SEED);
  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAPS);
  localparam int               TC_W     = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TC_W-1:0]  TC_MAX   = TC_W'(TICK_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAND  = 2'd1,
    S_PLAY  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] seed, seed_n, seed_pre, lfsr_next, ld_seed;
  logic [TC_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0] gen, gen_n;
  logic             load_eff;
  logic             tick_i;
  logic             play_entry;

`ifdef SEED_LOAD_EN
  assign load_eff = load;
  assign ld_seed  = (inputSeed == '0) ? DEF_SEED : inputSeed;
`else
  logic unused_load;
  assign load_eff    = 1'b0;
  assign ld_seed     = DEF_SEED;
  assign unused_load = ^{load, inputSeed};
`endif

  assign lfsr_next = {seed[WIDTH-2:0], ^(seed & TAP_MASK)};

  // Handshake-free level inputs: every input is a level sampled on the rising
  // edge; priority is randomize > load > pause > start in every state.
  always_comb begin
    state_n  = state;
    seed_pre = seed;
    case (state)
      S_IDLE: begin
        if (randomize)     state_n = S_RAND;
        else if (load_eff) seed_pre = ld_seed;
        else if (start)    state_n = S_PLAY;
      end
      S_RAND: begin
        seed_pre = lfsr_next;
        if (!randomize && load_eff) begin
          state_n  = S_IDLE;
          seed_pre = ld_seed;
        end else if (!randomize && start) begin
          state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (randomize) state_n = S_RAND;
        else if (load_eff) begin
          state_n  = S_IDLE;
          seed_pre = ld_seed;
        end else if (pause) state_n = S_PAUSE;
      end
      S_PAUSE: begin
        if (randomize) state_n = S_RAND;
        else if (load_eff) begin
          state_n  = S_IDLE;
          seed_pre = ld_seed;
        end else if (start) state_n = S_PLAY;
      end
      default: state_n = S_IDLE;
    endcase
    // An all-zero LFSR would lock up, so zero is never allowed into the register.
    seed_n = (seed_pre == '0) ? DEF_SEED : seed_pre;
  end

  assign tick_i     = (state == S_PLAY) && (cnt == TC_MAX);
  assign play_entry = (state_n == S_PLAY) && ((state == S_IDLE) || (state == S_RAND));

  // Resuming from PAUSE keeps the partial tick count; a fresh start clears it.
  always_comb begin
    cnt_n = cnt;
    gen_n = gen;
    if (play_entry) begin
      cnt_n = '0;
      gen_n = '0;
    end else if (state == S_PLAY) begin
      cnt_n = tick_i ? '0 : cnt + TC_W'(1);
      if (tick_i) gen_n = gen + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      seed  <= DEF_SEED;
      cnt   <= '0;
      gen   <= '0;
    end else begin
      state <= state_n;
      seed  <= seed_n;
      cnt   <= cnt_n;
      gen   <= gen_n;
    end
  end

  assign outputSeed = seed;
  assign seed_valid = (state != S_RAND);
  assign playing    = (state == S_PLAY);
  assign tick       = tick_i;
  assign gen_count  = gen;
  assign state_dbg  = state;

endmodule

// File: tb/tb_seed_sequencer.sv
// Self-checking bench for seed_sequencer: vector table plus hand-written
// sequences for pause/resume, asynchronous reset and tick latency.
module tb_seed_sequencer;

  localparam int W  = 64;
  localparam int CW = 16;
  localparam int TP = 4;
  localparam int EW = W + 3 + CW;

  localparam logic [W-1:0] D  = 64'h0412_6424_0034_3CA8;
  localparam logic [W-1:0] L1 = 64'h0824_C848_0068_7950;
  localparam logic [W-1:0] L2 = 64'h1049_9090_00D0_F2A1;
  localparam logic [W-1:0] L3 = 64'h2093_2120_01A1_E543;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          rnd = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  inputSeed = '0;
  logic [W-1:0]  outputSeed;
  logic          seed_valid;
  logic          playing;
  logic          tick;
  logic [CW-1:0] gen_count;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  seed_sequencer #(
    .WIDTH(W), .DEFAULT_SEED(64'h0412_6424_0034_3CA8), .TAPS(64'hD800_0000_0000_0000),
    .TICK_PERIOD(TP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .randomize(rnd),
    .load(load), .inputSeed(inputSeed), .outputSeed(outputSeed),
    .seed_valid(seed_valid), .playing(playing), .tick(tick),
    .gen_count(gen_count), .state_dbg(state_dbg)
  );

  typedef struct {
    logic          r, l, p, s;
    logic [W-1:0]  din;
    logic [W-1:0]  seed;
    logic          valid, play, tk;
    logic [CW-1:0] gen;
  } vec_t;

  vec_t         vecs[$];
  logic [EW-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic add(input logic r, l, p, s, input logic [W-1:0] din, sd,
                     input logic vl, pl, tk, input logic [CW-1:0] g);
    vec_t x;
    x.r = r; x.l = l; x.p = p; x.s = s; x.din = din;
    x.seed = sd; x.valid = vl; x.play = pl; x.tk = tk; x.gen = g;
    vecs.push_back(x);
  endtask

  task automatic expect_out(input logic [W-1:0] sd, input logic vl, pl, tk,
                            input logic [CW-1:0] g);
    exp_q.push_back({sd, vl, pl, tk, g});
  endtask

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".seed"},    outputSeed,          e[EW-1 -: W]);
    cmp({tag, ".valid"},   W'(seed_valid),      W'(e[CW+2]));
    cmp({tag, ".playing"}, W'(playing),         W'(e[CW+1]));
    cmp({tag, ".tick"},    W'(tick),            W'(e[CW]));
    cmp({tag, ".gen"},     W'(gen_count),       W'(e[CW-1:0]));
  endtask

  task automatic drive(input logic r, l, p, s, input logic [W-1:0] din);
    @(negedge clk);
    rnd = r; load = l; pause = p; start = s; inputSeed = din;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // r l p s din      seed valid play tick gen
    add(0,0,0,0,'0,  D, 1,0,0,0);   // idle
    add(1,0,0,0,'0,  D, 0,0,0,0);   // enter RAND
    add(0,0,0,1,'0,  L1,1,1,0,0);   // one LFSR step, PLAY
    add(0,0,0,0,'0,  L1,1,1,0,0);
    add(0,0,0,0,'0,  L1,1,1,0,0);
    add(0,0,0,0,'0,  L1,1,1,1,0);   // PLAY cycle 4
    add(0,0,0,0,'0,  L1,1,1,0,1);
    add(0,0,0,0,'0,  L1,1,1,0,1);
    add(0,0,0,0,'0,  L1,1,1,0,1);
    add(0,0,0,0,'0,  L1,1,1,1,1);   // PLAY cycle 8
    add(0,0,0,0,'0,  L1,1,1,0,2);
    add(0,0,0,0,'0,  L1,1,1,0,2);
    add(0,0,0,0,'0,  L1,1,1,0,2);
    add(0,0,0,0,'0,  L1,1,1,1,2);   // PLAY cycle 12
    add(0,0,0,0,'0,  L1,1,1,0,3);
    add(0,0,0,0,'0,  L1,1,1,0,3);
    add(0,0,0,0,'0,  L1,1,1,0,3);
    for (int k = 0; k < 5; k++) add(0,0,1,0,'0, L1,1,0,0,3);  // paused 5 cycles
    add(0,0,0,1,'0,  L1,1,1,1,3);   // resume lands on remaining count
    add(0,0,0,0,'0,  L1,1,1,0,4);
    add(0,0,0,0,'0,  L1,1,1,0,4);
    add(0,0,0,0,'0,  L1,1,1,0,4);
    add(0,0,0,0,'0,  L1,1,1,1,4);
    add(0,0,1,0,'0,  L1,1,0,0,5);   // pause in tick cycle still counts
    add(0,0,0,1,'0,  L1,1,1,0,5);
    add(0,0,0,1,'0,  L1,1,1,0,5);   // start ignored in PLAY
    add(1,1,0,0,64'h1, L1,0,0,0,5); // randomize beats load
    add(0,0,0,0,'0,  L2,0,0,0,5);
    add(0,0,0,1,'0,  L3,1,1,0,0);   // fresh start clears gen_count
`ifdef SEED_LOAD_EN
    add(0,1,0,0,64'h1, 64'h1,1,0,0,0);  // load from PLAY to IDLE
    add(0,1,0,0,'0,  D, 1,0,0,0);        // zero load replaced by default
    add(1,1,0,0,64'h5, D, 0,0,0,0);      // randomize beats load in IDLE
    add(0,0,0,1,'0,  L1,1,1,0,0);
`else
    add(0,1,0,0,64'h1, L3,1,1,0,0);     // load ignored
    add(0,1,0,0,'0,  L3,1,1,0,0);
    add(0,1,1,0,64'h7, L3,1,0,0,0);     // pause still acts
    add(0,0,0,1,'0,  L3,1,1,1,0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_out(D, 1, 0, 0, 0);
    check_out("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].l, vecs[i].p, vecs[i].s, vecs[i].din);
      expect_out(vecs[i].seed, vecs[i].valid, vecs[i].play, vecs[i].tk, vecs[i].gen);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i));
    end

    // Reset in the middle of PLAY with a nonzero generation count.
    drive(0, 0, 0, 0, '0);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b1;
    expect_out(D, 1, 0, 0, 0);
    #1;
    check_out("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // Tick latency after a start from IDLE.
    drive(0, 0, 0, 1, '0);
    expect_out(D, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    check_out("start_idle");
    cyc = 0;
    while (!tick && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    cmp("tick_latency", W'(cyc), W'(TP - 1));
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seed_sequencer.md
# seed_sequencer

Parametrised seed-and-pacing controller for the cellular-automaton playfield. It selects the board seed from a fixed default, a free-running LFSR, or an externally loaded value. It sequences the game through idle, randomize, play and pause modes. While playing, it paces generation updates with a programmable tick and a generation counter.

## Interface
Parameters:
- WIDTH, 64, seed/LFSR width in bits (≥ 4)
- DEFAULT_SEED, 64'h0412_6424_0034_3CA8, seed after reset; also replaces any all-zero seed (truncated/zero-extended to WIDTH)
- TAPS, 64'hD800_0000_0000_0000, LFSR feedback mask (bit i set ⇒ seed[i] feeds back)
- TICK_PERIOD, 4, cycles between generation ticks in PLAY (≥ 1)
- CNT_W, 16, generation counter width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- start  input  1  level; enter/resume PLAY
- pause  input  1  level; PLAY → PAUSE
- randomize  input  1  level; enter RAND
- load  input  1  level; capture inputSeed (see Configuration)
- inputSeed  input  WIDTH  external seed
- outputSeed  output  WIDTH  current board seed
- seed_valid  output  1  seed stable (low only in RAND)
- playing  output  1  high in PLAY
- tick  output  1  one-cycle generation strobe
- gen_count  output  CNT_W  generations elapsed since last play start

## Operation
- States: IDLE, RAND, PLAY, PAUSE. All inputs are sampled on the clock edge.
- Input priority, highest first: randomize > load > pause > start.
- IDLE:
  - randomize → RAND.
  - load → stay in IDLE; seed ← inputSeed, or DEFAULT_SEED if inputSeed is 0.
  - start → PLAY.
- RAND:
  - The LFSR steps every cycle spent in RAND: seed ← {seed[WIDTH-2:0], ^(seed & TAPS)}.
  - start → PLAY; seed freezes at its last value.
  - load → IDLE with the loaded seed.
  - Otherwise stay in RAND, whether or not randomize is still held.
- PLAY:
  - randomize → RAND.
  - load → IDLE with the loaded seed.
  - pause → PAUSE.
  - start is ignored.
- PAUSE:
  - randomize → RAND.
  - load → IDLE.
  - start → PLAY (resume).
  - pause is ignored.
- Tick counter (0..TICK_PERIOD-1):
  - Increments each PLAY cycle and wraps at TICK_PERIOD-1.
  - Holds in PAUSE.
  - Clears to 0 on entry to PLAY from IDLE or RAND, but not on resume from PAUSE.
- gen_count:
  - Increments on each tick and wraps modulo 2^CNT_W.
  - Holds in PAUSE.
  - Clears on entry to PLAY from IDLE or RAND.
- Zero lockup guard: any transition that would leave seed = 0 loads DEFAULT_SEED instead.

## Timing
- Reset values:
  - state IDLE.
  - outputSeed = DEFAULT_SEED.
  - seed_valid = 1.
  - playing = 0.
  - tick = 0.
  - gen_count = 0.
  - tick counter = 0.
- State, seed and gen_count are registered; each change is visible the cycle after the sampling edge.
- playing and seed_valid are decoded from the state register, so they change in the same cycle as the state.
- tick = (state == PLAY) && (cnt == TICK_PERIOD-1):
  - If playing first rises in cycle N, ticks occur at N+TICK_PERIOD-1, N+2·TICK_PERIOD-1, …
  - TICK_PERIOD = 1 gives tick in every PLAY cycle.
- A pause sampled in the tick cycle still lets that tick count; the counter then holds.
- Reset asserted mid-operation returns every register to its reset value immediately; no partial update.

## Configuration
- SEED_LOAD_EN defined: the load input behaves as above.
- SEED_LOAD_EN undefined:
  - load and inputSeed are ignored (ports kept, unused).
  - Seeds come only from DEFAULT_SEED or the LFSR.
  - Priority becomes randomize > pause > start.

## Test plan
- Reset, no inputs → outputSeed = 64'h0412_6424_0034_3CA8, seed_valid = 1, playing = 0, gen_count = 0.
- randomize for 1 cycle, then start on the next edge → one LFSR step; outputSeed = 64'h0824_C848_0068_7950; seed_valid low for 1 cycle; then playing = 1.
- start from IDLE, TICK_PERIOD = 4, run 12 cycles → tick at PLAY cycles 4, 8, 12; gen_count = 3.
- In PLAY:
  - Pause for 5 cycles → no tick; gen_count holds.
  - Then start → the next tick arrives exactly at the remaining count.
- load with inputSeed = 0 (SEED_LOAD_EN) → outputSeed = DEFAULT_SEED.
- load with inputSeed = 64'h1 → outputSeed = 64'h1.
- randomize and load in the same cycle → RAND wins.
- reset asserted mid-PLAY → all outputs return to reset values without waiting for a clock edge.
